// File: rtl/sprite_blitter.sv
// sprite_blitter: copies one palette-encoded sprite from sprite ROM into the
// frame RAM at (sprite_x, sprite_y). One texel is issued per cycle in raster
// order. Transparent texels are dropped and off-screen texels are clipped.
// The ROM has one cycle of read latency, so each write happens one cycle
// after its texel is issued.
module sprite_blitter #(
  parameter int         SPRITE_W    = 24,
  parameter int         SPRITE_H    = 45,
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter logic [4:0] TRANSPARENT = 5'h15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [15:0] sprite_base,
  input  logic        flip_h,
  output logic [15:0] rom_addr,
  input  logic [4:0]  rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [4:0]  fb_data,
  output logic        busy,
  output logic        done
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Blit parameters captured at start; later input changes are ignored.
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [15:0]   r_base;
  logic          r_flip;

  logic          r_vld_p1;
  logic [18:0]   r_addr_p1;
  logic          r_vis_p1;

  logic          w_issue;
  logic          w_col_end;
  logic          w_last;
  logic [15:0]   w_col16;
  logic [15:0]   w_row16;
  logic [15:0]   w_rom_addr;
  logic [10:0]   w_px;
  logic [10:0]   w_py;
  logic          w_vis;
  logic [18:0]   w_addr;

  assign w_issue   = (r_state == S_RUN);
  assign w_col_end = (r_col == CW'(SPRITE_W - 1));
  assign w_last    = w_col_end && (r_row == RW'(SPRITE_H - 1));

  // Issue stage: ROM address plus screen position of the current texel.
  assign w_col16    = 16'(r_col);
  assign w_row16    = 16'(r_row);
  assign w_rom_addr = r_base + w_row16 * 16'(SPRITE_W)
                    + (r_flip ? (16'(SPRITE_W - 1) - w_col16) : w_col16);
  assign w_px   = 11'(r_x) + 11'(r_col);
  assign w_py   = 11'(r_y) + 11'(r_row);
  assign w_vis  = (w_px < 11'(SCREEN_W)) && (w_py < 11'(SCREEN_H));
  assign w_addr = 19'(w_py) * 19'(SCREEN_W) + 19'(w_px);

  // Control: state, raster counters and the issue valid flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_state <= S_DRAIN;
            r_col   <= '0;
            r_row   <= '0;
          end else if (w_col_end) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture the blit request when it is accepted in IDLE.
  always_ff @(posedge Clk) begin
    if (r_state == S_IDLE && start) begin
      r_x    <= sprite_x;
      r_y    <= sprite_y;
      r_base <= sprite_base;
      r_flip <= flip_h;
    end
  end

  // ---- stage p0 -> p1: frame address and visibility wait for ROM data ----
  always_ff @(posedge Clk) begin
    r_addr_p1 <= w_addr;
    r_vis_p1  <= w_vis;
  end

  // ---- stage p1: write port, driven only while a texel is in flight ----
  assign rom_addr = w_issue ? w_rom_addr : '0;
  assign fb_we    = r_vld_p1 && r_vis_p1 && (rom_data != TRANSPARENT);
  assign fb_addr  = r_vld_p1 ? r_addr_p1 : '0;
  assign fb_data  = r_vld_p1 ? rom_data : '0;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter with a 4x2 sprite: a table of directed blits,
// randomized blits, start-held and mid-blit reset sequences, all checked
// cycle by cycle against a raster-order model of the blit.
module tb_sprite_blitter;

  localparam int SW   = 4;
  localparam int SH   = 2;
  localparam int NT   = SW * SH;
  localparam int MAXC = 24;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [15:0] sprite_base;
  logic        flip_h;
  logic [15:0] rom_addr;
  logic [4:0]  rom_data;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [4:0]  fb_data;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  rom [0:65535];

  logic        rec_busy [0:MAXC-1];
  logic        rec_done [0:MAXC-1];
  logic        rec_we   [0:MAXC-1];
  logic [18:0] rec_addr [0:MAXC-1];
  logic [4:0]  rec_data [0:MAXC-1];
  logic [15:0] rec_rom  [0:MAXC-1];

  int st_nwr, st_a0, st_alast, st_rom0, st_done;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] base;
    logic        flip;
    logic [7:0]  tmask;
    int          nwr;
    int          a0;
    int          alast;
    int          rom0;
    int          donec;
  } vec_t;

  vec_t tbl [0:4];

  sprite_blitter #(.SPRITE_W(SW), .SPRITE_H(SH)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_base(sprite_base),
    .flip_h(flip_h), .rom_addr(rom_addr), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM: data one cycle after the address.
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] src_of(input int i, input logic [15:0] base, input logic flip);
    int r, c;
    r = i / SW;
    c = i % SW;
    return base + 16'(r * SW + (flip ? (SW - 1 - c) : c));
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clk);
    while (busy && n < 64) begin
      @(negedge Clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Runs one blit and checks every cycle 1..ncmp against the model.
  task automatic run_blit(input logic [9:0] x, input logic [9:0] y,
                          input logic [15:0] base, input logic flip,
                          input bit hold, input int ncmp, input string tag);
    @(negedge Clk);
    sprite_x = x; sprite_y = y; sprite_base = base; flip_h = flip; start = 1'b1;
    @(posedge Clk);
    #1;
    if (!hold) start = 1'b0;
    sprite_x    = 10'($urandom_range(0, 1023));
    sprite_y    = 10'($urandom_range(0, 1023));
    sprite_base = 16'($urandom_range(0, 65535));
    flip_h      = ~flip;
    for (int k = 1; k < MAXC; k++) begin
      @(negedge Clk);
      rec_busy[k] = busy; rec_done[k] = done; rec_we[k] = fb_we;
      rec_addr[k] = fb_addr; rec_data[k] = fb_data; rec_rom[k] = rom_addr;
      if (!hold && k == 5) start = 1'b1;
      if (!hold && k == 6) start = 1'b0;
      if (hold && k == 12) start = 1'b0;
    end
    st_nwr = 0; st_a0 = -1; st_alast = -1; st_rom0 = int'(rec_rom[1]); st_done = -1;
    for (int k = 1; k <= ncmp; k++) begin
      logic        eb, ed, ew;
      logic [18:0] ea;
      logic [4:0]  edat;
      int          i, px, py;
      eb = (k <= NT + 2);
      ed = (k == NT + 2);
      ew = 1'b0; ea = '0; edat = '0;
      if (k >= 2 && k <= NT + 1) begin
        i    = k - 2;
        px   = int'(x) + (i % SW);
        py   = int'(y) + (i / SW);
        edat = rom[src_of(i, base, flip)];
        ea   = 19'(py * 640 + px);
        ew   = (px < 640) && (py < 480) && (edat != 5'h15);
      end
      chk($sformatf("%s_busy_c%0d", tag, k), 32'(rec_busy[k]), 32'(eb));
      chk($sformatf("%s_done_c%0d", tag, k), 32'(rec_done[k]), 32'(ed));
      chk($sformatf("%s_we_c%0d", tag, k), 32'(rec_we[k]), 32'(ew));
      if (ew) begin
        chk($sformatf("%s_addr_c%0d", tag, k), 32'(rec_addr[k]), 32'(ea));
        chk($sformatf("%s_data_c%0d", tag, k), 32'(rec_data[k]), 32'(edat));
      end
      if (k <= NT)
        chk($sformatf("%s_rom_c%0d", tag, k), 32'(rec_rom[k]), 32'(src_of(k - 1, base, flip)));
      if (rec_we[k] === 1'b1) begin
        st_nwr++;
        if (st_a0 < 0) st_a0 = int'(rec_addr[k]);
        st_alast = int'(rec_addr[k]);
      end
      if (rec_done[k] === 1'b1 && st_done < 0) st_done = k;
    end
  endtask

  task automatic fill_seq(input logic [15:0] base, input logic [7:0] tmask);
    for (int i = 0; i < NT; i++)
      rom[base + 16'(i)] = tmask[i] ? 5'h15 : 5'(i);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = '0;
    Reset = 1'b1; start = 1'b0; sprite_x = '0; sprite_y = '0;
    sprite_base = '0; flip_h = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);

    //          x        y        base      flip  tmask        nwr a0      alast   rom0 done
    tbl[0] = '{10'd10,  10'd3,   16'd0,    1'b0, 8'h00,       8,  1930,   2573,   0,   10};
    tbl[1] = '{10'd10,  10'd3,   16'd0,    1'b0, 8'b00100100, 6,  1930,   2573,   0,   10};
    tbl[2] = '{10'd638, 10'd479, 16'd0,    1'b0, 8'h00,       2,  307198, 307199, 0,   10};
    tbl[3] = '{10'd10,  10'd3,   16'd100,  1'b1, 8'h00,       8,  1930,   2573,   103, 10};
    tbl[4] = '{10'd640, 10'd5,   16'd0,    1'b0, 8'h00,       0,  -1,     -1,     0,   10};

    for (int t = 0; t < 5; t++) begin
      fill_seq(tbl[t].base, tbl[t].tmask);
      run_blit(tbl[t].x, tbl[t].y, tbl[t].base, tbl[t].flip, 1'b0, NT + 3, $sformatf("t%0d", t));
      chk($sformatf("t%0d_nwr", t), 32'(st_nwr), 32'(tbl[t].nwr));
      chk($sformatf("t%0d_a0", t), 32'(st_a0), 32'(tbl[t].a0));
      chk($sformatf("t%0d_alast", t), 32'(st_alast), 32'(tbl[t].alast));
      chk($sformatf("t%0d_rom0", t), 32'(st_rom0), 32'(tbl[t].rom0));
      chk($sformatf("t%0d_donec", t), 32'(st_done), 32'(tbl[t].donec));
      wait_idle();
    end

    // start held high: single blit, restart only once IDLE is re-entered.
    fill_seq(16'd0, 8'h00);
    run_blit(10'd10, 10'd3, 16'd0, 1'b0, 1'b1, NT + 3, "hold");
    chk("hold_restart_c12", 32'(rec_busy[12]), 32'd1);
    wait_idle();

    // Reset during RUN cycle 4.
    @(negedge Clk);
    sprite_x = 10'd10; sprite_y = 10'd3; sprite_base = 16'd0; flip_h = 1'b0; start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_mid_we", 32'(fb_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_rom_addr", 32'(rom_addr), 32'd0);
    Reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      chk($sformatf("rst_after_done_%0d", k), 32'(done), 32'd0);
      chk($sformatf("rst_after_we_%0d", k), 32'(fb_we), 32'd0);
    end
    run_blit(10'd10, 10'd3, 16'd0, 1'b0, 1'b0, NT + 3, "post_rst");
    chk("post_rst_nwr", 32'(st_nwr), 32'd8);
    wait_idle();

    // Randomized blits against the model.
    for (int r = 0; r < 8; r++) begin
      logic [9:0]  rx, ry;
      logic [15:0] rb;
      logic        rf;
      rx = 10'($urandom_range(0, 659));
      ry = 10'($urandom_range(0, 499));
      rb = 16'($urandom_range(0, 65535));
      rf = 1'($urandom_range(0, 1));
      for (int i = 0; i < NT; i++)
        rom[rb + 16'(i)] = ($urandom_range(0, 3) == 0) ? 5'h15 : 5'($urandom_range(0, 31));
      run_blit(rx, ry, rb, rf, 1'b0, NT + 3, $sformatf("rnd%0d", r));
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
